// File: rtl/ddy_islem_if.sv
// ddy_islem_if: instruction, DDY oku/yaz, exception and writeback
// signals of the execute-stage CSR initiator.
interface ddy_islem_if #(
  parameter int PS_BIT    = 32,
  parameter int ODD_BIT   = 5,
  parameter int ADRES_BIT = 32
);
  logic                 buyruk_gecerli_g;
  logic                 buyruk_hazir_c;
  logic [2:0]           islem_g;
  logic [11:0]          ddy_adres_g;
  logic [31:0]          rs1_veri_g;
  logic [4:0]           uimm_g;
  logic                 rs1_sifir_g;
  logic                 rd_sifir_g;
  logic [PS_BIT-1:0]    ps_g;

  logic                 oku_gecerli_c;
  logic [11:0]          oku_adres_c;
  logic [31:0]          oku_veri_g;
  logic                 yaz_gecerli_c;
  logic [11:0]          yaz_adres_c;
  logic [31:0]          yaz_veri_c;

  logic                 yoy_odd_c;
  logic [ODD_BIT-1:0]   odd_kod_c;
  logic [PS_BIT-1:0]    odd_ps_c;
  logic [ADRES_BIT-1:0] odd_adres_c;

  logic                 sonuc_gecerli_c;
  logic [31:0]          sonuc_veri_c;
  logic                 sonuc_hazir_g;

  modport master (
    input  buyruk_gecerli_g,
    output buyruk_hazir_c,
    input  islem_g,
    input  ddy_adres_g,
    input  rs1_veri_g,
    input  uimm_g,
    input  rs1_sifir_g,
    input  rd_sifir_g,
    input  ps_g,
    output oku_gecerli_c,
    output oku_adres_c,
    input  oku_veri_g,
    output yaz_gecerli_c,
    output yaz_adres_c,
    output yaz_veri_c,
    output yoy_odd_c,
    output odd_kod_c,
    output odd_ps_c,
    output odd_adres_c,
    output sonuc_gecerli_c,
    output sonuc_veri_c,
    input  sonuc_hazir_g
  );

  modport slave (
    output buyruk_gecerli_g,
    input  buyruk_hazir_c,
    output islem_g,
    output ddy_adres_g,
    output rs1_veri_g,
    output uimm_g,
    output rs1_sifir_g,
    output rd_sifir_g,
    output ps_g,
    input  oku_gecerli_c,
    input  oku_adres_c,
    output oku_veri_g,
    input  yaz_gecerli_c,
    input  yaz_adres_c,
    input  yaz_veri_c,
    input  yoy_odd_c,
    input  odd_kod_c,
    input  odd_ps_c,
    input  odd_adres_c,
    input  sonuc_gecerli_c,
    input  sonuc_veri_c,
    output sonuc_hazir_g
  );
endinterface

// File: rtl/ddy_islem_birimi.sv
// ddy_islem_birimi: execute-stage CSR read-modify-write initiator.
// Old CSR value goes to writeback; MRET and illegal access raise yoy_odd.
module ddy_islem_birimi #(
  parameter int PS_BIT    = 32,
  parameter int ODD_BIT   = 5,
  parameter int ADRES_BIT = 32,
  parameter logic [ODD_BIT-1:0] KOD_YB   = ODD_BIT'(2),
  parameter logic [ODD_BIT-1:0] KOD_MRET = ODD_BIT'(16)
) (
  input logic         clk_g,
  input logic         rst_g,
  ddy_islem_if.master bus
);
  localparam logic [11:0] DDY_MSTATUS  = 12'h300;
  localparam logic [11:0] DDY_MIE      = 12'h304;
  localparam logic [11:0] DDY_MTVEC    = 12'h305;
  localparam logic [11:0] DDY_MSCRATCH = 12'h340;
  localparam logic [11:0] DDY_MEPC     = 12'h341;
  localparam logic [11:0] DDY_MCAUSE   = 12'h342;
  localparam logic [11:0] DDY_MTVAL    = 12'h343;
  localparam logic [11:0] DDY_MIP      = 12'h344;
  localparam logic [11:0] DDY_MCYCLE   = 12'hC00;
  localparam logic [11:0] DDY_MTIME    = 12'hC01;

  typedef enum logic [2:0] {
    BOSTA, OKU, YAZ, SONUC, ODD
  } durum_t;

  durum_t durum;

  logic [1:0]           tur_r;
  logic [31:0]          op_r;
  logic [11:0]          adres_r;
  logic                 yazma_r;
  logic [31:0]          eski_r;

  logic                 oku_r;
  logic                 yaz_r;
  logic [31:0]          yaz_veri_r;
  logic                 odd_r;
  logic [ODD_BIT-1:0]   kod_r;
  logic [PS_BIT-1:0]    ps_r;
  logic [ADRES_BIT-1:0] odd_adres_r;
  logic                 sonuc_r;
  logic [31:0]          sonuc_veri_r;

  logic [1:0]  tur;
  logic [31:0] op;
  logic        mret;
  logic        adres_ok;
  logic        salt_oku;
  logic        yazma;
  logic        okuma;
  logic        yasak;

  // tur: 00 MRET/reserved, 01 RW, 10 RS, 11 RC
  always_comb begin
    tur      = bus.islem_g[1:0];
    mret     = (bus.islem_g == 3'b000);
    op       = bus.islem_g[2] ? {27'b0, bus.uimm_g}
                              : bus.rs1_veri_g;
    adres_ok = bus.ddy_adres_g inside {
                 DDY_MSCRATCH, DDY_MEPC, DDY_MTVEC,
                 DDY_MCAUSE, DDY_MTVAL, DDY_MSTATUS,
                 DDY_MIP, DDY_MIE, DDY_MCYCLE,
                 DDY_MTIME};
    salt_oku = (bus.ddy_adres_g[11:10] == 2'b11);
    yazma    = (tur == 2'b01) ||
               ((tur != 2'b00) && !bus.rs1_sifir_g);
    okuma    = !((tur == 2'b01) && bus.rd_sifir_g);
    yasak    = !adres_ok || (tur == 2'b00) ||
               (yazma && salt_oku);
  end

  logic [31:0] eski_v;
  logic [31:0] yeni_v;

  // read data is only trusted in a cycle we actually strobed oku
  always_comb begin
    eski_v = oku_r ? bus.oku_veri_g : 32'b0;
    yeni_v = eski_v;
    unique case (1'b1)
      (tur_r == 2'b01): yeni_v = op_r;
      (tur_r == 2'b10): yeni_v = eski_v | op_r;
      (tur_r == 2'b11): yeni_v = eski_v & ~op_r;
      default:          yeni_v = eski_v;
    endcase
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      durum        <= BOSTA;
      tur_r        <= '0;
      op_r         <= '0;
      adres_r      <= '0;
      yazma_r      <= 1'b0;
      eski_r       <= '0;
      oku_r        <= 1'b0;
      yaz_r        <= 1'b0;
      yaz_veri_r   <= '0;
      odd_r        <= 1'b0;
      kod_r        <= '0;
      ps_r         <= '0;
      odd_adres_r  <= '0;
      sonuc_r      <= 1'b0;
      sonuc_veri_r <= '0;
    end else begin
      oku_r <= 1'b0;
      yaz_r <= 1'b0;
      odd_r <= 1'b0;
      unique case (durum)
        BOSTA: begin
          if (bus.buyruk_gecerli_g) begin
            tur_r   <= tur;
            op_r    <= op;
            adres_r <= bus.ddy_adres_g;
            yazma_r <= yazma;
            if (mret || yasak) begin
              durum       <= ODD;
              odd_r       <= 1'b1;
              kod_r       <= mret ? KOD_MRET : KOD_YB;
              ps_r        <= bus.ps_g;
              odd_adres_r <= mret ? '0
                           : ADRES_BIT'(bus.ddy_adres_g);
            end else begin
              durum <= OKU;
              oku_r <= okuma;
            end
          end
        end
        OKU: begin
          eski_r <= eski_v;
          if (yazma_r) begin
            durum      <= YAZ;
            yaz_r      <= 1'b1;
            yaz_veri_r <= yeni_v;
          end else begin
            durum        <= SONUC;
            sonuc_r      <= 1'b1;
            sonuc_veri_r <= eski_v;
          end
        end
        YAZ: begin
          durum        <= SONUC;
          sonuc_r      <= 1'b1;
          sonuc_veri_r <= eski_r;
        end
        SONUC: begin
          if (bus.sonuc_hazir_g) begin
            durum   <= BOSTA;
            sonuc_r <= 1'b0;
          end
        end
        ODD: begin
          durum <= BOSTA;
        end
        default: begin
          durum <= BOSTA;
        end
      endcase
    end
  end

  assign bus.buyruk_hazir_c  = (durum == BOSTA);
  assign bus.oku_gecerli_c   = oku_r;
  assign bus.oku_adres_c     = adres_r;
  assign bus.yaz_gecerli_c   = yaz_r;
  assign bus.yaz_adres_c     = adres_r;
  assign bus.yaz_veri_c      = yaz_veri_r;
  assign bus.yoy_odd_c       = odd_r;
  assign bus.odd_kod_c       = kod_r;
  assign bus.odd_ps_c        = ps_r;
  assign bus.odd_adres_c     = odd_adres_r;
  assign bus.sonuc_gecerli_c = sonuc_r;
  assign bus.sonuc_veri_c    = sonuc_veri_r;
endmodule

// File: tb/tb_ddy_islem_birimi.sv
// tb_ddy_islem_birimi: directed CSR instructions against a cycle
// schedule predicted from instruction semantics and a model CSR file.
module tb_ddy_islem_birimi;
  localparam logic [4:0] KOD_YB   = 5'd2;
  localparam logic [4:0] KOD_MRET = 5'd16;

  logic clk_g = 1'b0;
  logic rst_g = 1'b0;
  always #5 clk_g = ~clk_g;

  ddy_islem_if bus ();

  ddy_islem_birimi dut (
    .clk_g(clk_g),
    .rst_g(rst_g),
    .bus  (bus)
  );

  typedef struct {
    logic        hazir;
    logic        oku;
    logic [11:0] oku_adres;
    logic        yaz;
    logic [11:0] yaz_adres;
    logic [31:0] yaz_veri;
    logic        odd;
    logic [4:0]  kod;
    logic [31:0] ps;
    logic [31:0] oadres;
    logic        sonuc;
    logic [31:0] sveri;
  } bek_t;

  bek_t        sched [0:4095];
  logic [31:0] mdl [0:4095];
  logic [31:0] csr_mem [0:4095];
  int          cyc = 0;
  int          hz_from = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic bek_t bos();
    bek_t e;
    e.hazir = 1'b1; e.oku = 1'b0; e.oku_adres = '0;
    e.yaz = 1'b0; e.yaz_adres = '0; e.yaz_veri = '0;
    e.odd = 1'b0; e.kod = '0; e.ps = '0; e.oadres = '0;
    e.sonuc = 1'b0; e.sveri = '0;
    return e;
  endfunction

  task automatic chk(input string ad, input logic [31:0] g,
                     input logic [31:0] b);
    checks++;
    if (g !== b) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", ad, g, b, cyc);
    end
  endtask

  always @(posedge clk_g) cyc++;

  // CSR file stand-in: combinational read, write on strobe
  assign bus.oku_veri_g = bus.oku_gecerli_c
                        ? csr_mem[bus.oku_adres_c] : 32'hBAD0BAD0;
  always @(posedge clk_g)
    if (bus.yaz_gecerli_c)
      csr_mem[bus.yaz_adres_c] <= bus.yaz_veri_c;

  always @(negedge clk_g) bus.sonuc_hazir_g = (cyc >= hz_from);

  always @(negedge clk_g) begin
    bek_t e;
    e = sched[cyc];
    chk("hazir", 32'(bus.buyruk_hazir_c), 32'(e.hazir));
    chk("oku_gecerli", 32'(bus.oku_gecerli_c), 32'(e.oku));
    chk("yaz_gecerli", 32'(bus.yaz_gecerli_c), 32'(e.yaz));
    chk("yoy_odd", 32'(bus.yoy_odd_c), 32'(e.odd));
    chk("sonuc_gecerli", 32'(bus.sonuc_gecerli_c), 32'(e.sonuc));
    if (e.oku) chk("oku_adres", 32'(bus.oku_adres_c), 32'(e.oku_adres));
    if (e.yaz) begin
      chk("yaz_adres", 32'(bus.yaz_adres_c), 32'(e.yaz_adres));
      chk("yaz_veri", bus.yaz_veri_c, e.yaz_veri);
    end
    if (e.odd) begin
      chk("odd_kod", 32'(bus.odd_kod_c), 32'(e.kod));
      chk("odd_ps", bus.odd_ps_c, e.ps);
      chk("odd_adres", bus.odd_adres_c, e.oadres);
    end
    if (e.sonuc) chk("sonuc_veri", bus.sonuc_veri_c, e.sveri);
  end

  function automatic logic yasal(input logic [11:0] a);
    return a == 12'h340 || a == 12'h341 || a == 12'h305 ||
           a == 12'h342 || a == 12'h343 || a == 12'h300 ||
           a == 12'h344 || a == 12'h304 || a == 12'hC00 ||
           a == 12'hC01;
  endfunction

  task automatic komut(
    input string ad, input logic [2:0] islem,
    input logic [11:0] adr, input logic [31:0] rs1,
    input logic [4:0] uimm, input logic rs1z, input logic rdz,
    input logic [31:0] ps, input int bekle,
    input logic l_exc, input logic [4:0] l_kod,
    input logic l_yaz, input logic [31:0] l_wd,
    input logic [31:0] l_sonuc, input bit sifirla);
    int a, r, son;
    logic exc, rd, wr;
    logic [4:0] kod;
    logic [31:0] op, eski, wd, yedek;
    bek_t e;
    @(negedge clk_g);
    a = cyc + 1;
    yedek = 32'b0;
    op   = islem[2] ? {27'b0, uimm} : rs1;
    rd   = !(islem[1:0] == 2'b01 && rdz);
    eski = rd ? mdl[adr] : 32'b0;
    wr   = (islem[1:0] == 2'b01) || (islem[1:0] != 2'b00 && !rs1z);
    case (islem[1:0])
      2'b01:   wd = op;
      2'b10:   wd = eski | op;
      2'b11:   wd = eski & ~op;
      default: wd = 32'b0;
    endcase
    exc = (islem[1:0] == 2'b00) || !yasal(adr) ||
          (wr && adr[11:10] == 2'b11);
    kod = (islem == 3'b000) ? KOD_MRET : KOD_YB;
    chk({ad, " model exc"}, 32'(exc), 32'(l_exc));
    if (exc) begin
      chk({ad, " model kod"}, 32'(kod), 32'(l_kod));
      e = bos(); e.hazir = 1'b0; e.odd = 1'b1; e.kod = kod;
      e.ps = ps;
      e.oadres = (islem == 3'b000) ? 32'b0 : {20'b0, adr};
      sched[a] = e;
      son = a + 1;
    end else begin
      chk({ad, " model yaz"}, 32'(wr), 32'(l_yaz));
      if (wr) chk({ad, " model yaz_veri"}, wd, l_wd);
      chk({ad, " model sonuc"}, eski, l_sonuc);
      e = bos(); e.hazir = 1'b0; e.oku = rd; e.oku_adres = adr;
      sched[a] = e;
      r = a + 1;
      if (wr) begin
        e = bos(); e.hazir = 1'b0; e.yaz = 1'b1;
        e.yaz_adres = adr; e.yaz_veri = wd;
        sched[a+1] = e;
        r = a + 2;
        yedek = mdl[adr];
        mdl[adr] = wd;
      end
      for (int k = 0; k <= bekle; k++) begin
        e = bos(); e.hazir = 1'b0; e.sonuc = 1'b1; e.sveri = eski;
        sched[r+k] = e;
      end
      hz_from = r + bekle;
      son = r + bekle + 1;
    end
    bus.islem_g = islem; bus.ddy_adres_g = adr;
    bus.rs1_veri_g = rs1; bus.uimm_g = uimm;
    bus.rs1_sifir_g = rs1z; bus.rd_sifir_g = rdz;
    bus.ps_g = ps; bus.buyruk_gecerli_g = 1'b1;
    @(negedge clk_g);
    bus.buyruk_gecerli_g = 1'b0;
    bus.islem_g = 3'b001; bus.ddy_adres_g = 12'h340;
    bus.rs1_veri_g = 32'hFFFF_FFFF; bus.rs1_sifir_g = 1'b0;
    if (sifirla) begin
      @(negedge clk_g);
      #1 rst_g = 1'b0;
      #1;
      chk({ad, " rst yaz_gecerli"}, 32'(bus.yaz_gecerli_c), 32'd0);
      chk({ad, " rst hazir"}, 32'(bus.buyruk_hazir_c), 32'd1);
      chk({ad, " rst sonuc_gecerli"}, 32'(bus.sonuc_gecerli_c), 32'd0);
      chk({ad, " rst yaz_veri"}, bus.yaz_veri_c, 32'd0);
      for (int k = a + 2; k < son; k++) sched[k] = bos();
      mdl[adr] = yedek;
      @(negedge clk_g);
      #1 rst_g = 1'b1;
      son = cyc + 1;
    end
    while (cyc < son) @(negedge clk_g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sched[i] = bos(); mdl[i] = 32'b0; csr_mem[i] = 32'b0;
    end
    mdl[12'h340] = 32'h1234_5678; csr_mem[12'h340] = 32'h1234_5678;
    mdl[12'h300] = 32'h0000_0080; csr_mem[12'h300] = 32'h0000_0080;
    mdl[12'hC00] = 32'h0000_1234; csr_mem[12'hC00] = 32'h0000_1234;
    bus.buyruk_gecerli_g = 1'b0; bus.islem_g = '0;
    bus.ddy_adres_g = '0; bus.rs1_veri_g = '0; bus.uimm_g = '0;
    bus.rs1_sifir_g = 1'b0; bus.rd_sifir_g = 1'b0; bus.ps_g = '0;
    bus.sonuc_hazir_g = 1'b1;
    repeat (3) @(negedge clk_g);
    chk("reset sonuc_veri", bus.sonuc_veri_c, 32'd0);
    chk("reset yaz_veri", bus.yaz_veri_c, 32'd0);
    chk("reset odd_kod", 32'(bus.odd_kod_c), 32'd0);
    chk("reset odd_ps", bus.odd_ps_c, 32'd0);
    #1 rst_g = 1'b1;

    komut("csrrw mscratch", 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0,
          1'b0, 1'b0, 32'h10, 0,
          1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    komut("csrrs mstatus", 3'b010, 12'h300, 32'h8, 5'd0,
          1'b0, 1'b0, 32'h14, 0,
          1'b0, 5'd0, 1'b1, 32'h88, 32'h80, 1'b0);
    komut("csrrc mstatus", 3'b011, 12'h300, 32'h80, 5'd0,
          1'b0, 1'b0, 32'h18, 1,
          1'b0, 5'd0, 1'b1, 32'h08, 32'h88, 1'b0);
    komut("csrrsi mcycle 0", 3'b110, 12'hC00, 32'h0, 5'd0,
          1'b1, 1'b0, 32'h1C, 0,
          1'b0, 5'd0, 1'b0, 32'h0, 32'h1234, 1'b0);
    komut("csrrsi mcycle 1", 3'b110, 12'hC00, 32'h0, 5'd1,
          1'b0, 1'b0, 32'h20, 0,
          1'b1, KOD_YB, 1'b0, 32'h0, 32'h0, 1'b0);
    komut("csrrw 7c0", 3'b001, 12'h7C0, 32'h55, 5'd0,
          1'b0, 1'b0, 32'h100, 0,
          1'b1, KOD_YB, 1'b0, 32'h0, 32'h0, 1'b0);
    komut("mret", 3'b000, 12'h302, 32'h0, 5'd0,
          1'b1, 1'b1, 32'h200, 0,
          1'b1, KOD_MRET, 1'b0, 32'h0, 32'h0, 1'b0);
    komut("csrrw rd0 mepc", 3'b001, 12'h341, 32'h55, 5'd0,
          1'b0, 1'b1, 32'h204, 0,
          1'b0, 5'd0, 1'b1, 32'h55, 32'h0, 1'b0);
    komut("csrrwi mie", 3'b101, 12'h304, 32'h0, 5'h1F,
          1'b0, 1'b0, 32'h208, 0,
          1'b0, 5'd0, 1'b1, 32'h1F, 32'h0, 1'b0);
    komut("csrrci mie", 3'b111, 12'h304, 32'h0, 5'h03,
          1'b0, 1'b0, 32'h20C, 0,
          1'b0, 5'd0, 1'b1, 32'h1C, 32'h1F, 1'b0);
    komut("islem 100", 3'b100, 12'h340, 32'h1, 5'd0,
          1'b0, 1'b0, 32'h210, 0,
          1'b1, KOD_YB, 1'b0, 32'h0, 32'h0, 1'b0);
    komut("csrrs x0 hold", 3'b010, 12'h340, 32'hFFFF, 5'd0,
          1'b1, 1'b0, 32'h214, 5,
          1'b0, 5'd0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    komut("csrrw mtvec", 3'b001, 12'h305, 32'h8000_0000, 5'd0,
          1'b0, 1'b0, 32'h218, 2,
          1'b0, 5'd0, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    komut("csrrw mcause rst", 3'b001, 12'h342, 32'hAAAA_5555, 5'd0,
          1'b0, 1'b0, 32'h21C, 0,
          1'b0, 5'd0, 1'b1, 32'hAAAA_5555, 32'h0, 1'b1);
    komut("csrrs mcause after", 3'b010, 12'h342, 32'h0, 5'd0,
          1'b1, 1'b0, 32'h220, 0,
          1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

    chk("mem mstatus", csr_mem[12'h300], 32'h08);
    chk("mem mie", csr_mem[12'h304], 32'h1C);
    chk("mem mepc", csr_mem[12'h341], 32'h55);
    chk("mem mscratch", csr_mem[12'h340], 32'hDEAD_BEEF);
    chk("mem mcause", csr_mem[12'h342], 32'h0);
    chk("mem mcycle", csr_mem[12'hC00], 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
